// File: rtl/moon_pkg.sv
// Shared constants and the procedural moon image generator.
// The generator is reused to fill the sprite memory at elaboration.
package moon_pkg;

    localparam int SPRITE_W = 128;
    localparam int SPRITE_H = 128;
    localparam int ADDR_W   = 14;
    localparam int RGB_W    = 12;
    localparam int DEPTH    = SPRITE_W * SPRITE_H;

    localparam int RADIUS = 60;
    localparam int RIM_W  = 3;
    localparam int CTR    = 63;

    localparam logic [RGB_W-1:0] KEY_COLOR    = 12'hCCC;
    localparam logic [RGB_W-1:0] BASE_COLOR   = 12'hEEC;
    localparam logic [RGB_W-1:0] RIM_COLOR    = 12'hDDB;
    localparam logic [RGB_W-1:0] CRATER_COLOR = 12'hBBA;

    localparam int N_CRATER = 3;
    localparam int CR_X [N_CRATER] = '{45, 80, 55};
    localparam int CR_Y [N_CRATER] = '{40, 75, 90};
    localparam int CR_R [N_CRATER] = '{10, 14, 8};

    typedef logic [RGB_W-1:0] rgb_t;
    typedef rgb_t mem_t [DEPTH];

    function automatic rgb_t moon_pixel_gen(
        input logic [6:0] col,
        input logic [6:0] row
    );
        int   dx;
        int   dy;
        int   r2;
        int   cx;
        int   cy;
        rgb_t c;
        dx = int'(col) - CTR;
        dy = int'(row) - CTR;
        r2 = dx * dx + dy * dy;
        c  = BASE_COLOR;
        if (r2 > RADIUS * RADIUS) begin
            c = KEY_COLOR;
        end else if (r2 >= (RADIUS - RIM_W) * (RADIUS - RIM_W)) begin
            c = RIM_COLOR;
        end else begin
            for (int k = 0; k < N_CRATER; k++) begin
                cx = int'(col) - CR_X[k];
                cy = int'(row) - CR_Y[k];
                if (cx * cx + cy * cy < CR_R[k] * CR_R[k])
                    c = CRATER_COLOR;
            end
        end
        return c;
    endfunction

    function automatic mem_t moon_image();
        mem_t             img;
        logic [ADDR_W-1:0] adr;
        for (int i = 0; i < DEPTH; i++) begin
            adr    = ADDR_W'(i);
            img[i] = moon_pixel_gen(adr[6:0], adr[13:7]);
        end
        return img;
    endfunction

endpackage

// File: rtl/moon_sprite_rom_if.sv
// Renderer-side bus of the moon sprite memory.
// master = renderer, slave = memory.
interface moon_sprite_rom_if;
    import moon_pkg::*;

    logic [ADDR_W-1:0] a;
    logic              we;
    logic [RGB_W-1:0]  d;
    logic [RGB_W-1:0]  spo;
    logic [RGB_W-1:0]  qspo;

    modport master (
        output a, we, d,
        input  spo, qspo
    );

    modport slave (
        input  a, we, d,
        output spo, qspo
    );

endinterface

// File: rtl/moon_sprite_rom.sv
// 128x128 RGB444 moon sprite memory: async read, registered read,
// synchronous write overlay; image is built at elaboration.
import moon_pkg::*;

module moon_sprite_rom (
    input  logic             clk,
    input  logic             reset,
    moon_sprite_rom_if.slave bus
);

    mem_t mem_q = moon_image();
    rgb_t qspo_q;

    assign bus.spo  = mem_q[bus.a];
    assign bus.qspo = qspo_q;

    // Writes ignore reset so the overlay survives a reset pulse.
    always_ff @(posedge clk) begin
        if (bus.we)
            mem_q[bus.a] <= bus.d;
    end

    // Reads the pre-write word on a same-address write edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            qspo_q <= '0;
        else
            qspo_q <= mem_q[bus.a];
    end

endmodule

// File: tb/tb_moon_sprite_rom.sv
// Scoreboard bench for moon_sprite_rom: driver queues expectations,
// a negedge monitor pops and compares spo/qspo.
module tb_moon_sprite_rom;

    typedef struct {
        logic [13:0] a;
        logic [11:0] es;
        logic [11:0] eq;
        bit          nokey;
    } item_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    item_t       sb[$];
    logic [11:0] img [16384];

    moon_sprite_rom_if bus ();

    moon_sprite_rom dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic int radius2(input int adr);
        int c;
        int r;
        c = adr % 128;
        r = adr / 128;
        return (c - 63) * (c - 63) + (r - 63) * (r - 63);
    endfunction

    function automatic logic [11:0] model(input int adr);
        int c;
        int r;
        int r2;
        c  = adr % 128;
        r  = adr / 128;
        r2 = radius2(adr);
        if (r2 > 3600) return 12'hCCC;
        if (r2 >= 3249) return 12'hDDB;
        if ((c-45)*(c-45) + (r-40)*(r-40) < 100) return 12'hBBA;
        if ((c-80)*(c-80) + (r-75)*(r-75) < 196) return 12'hBBA;
        if ((c-55)*(c-55) + (r-90)*(r-90) < 64) return 12'hBBA;
        return 12'hEEC;
    endfunction

    task automatic check(input string nm, input logic [11:0] act,
                         input logic [11:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Monitor: one queued expectation per cycle, sampled at negedge.
    always @(negedge clk) begin
        item_t it;
        if (sb.size() > 0) begin
            it = sb.pop_front();
            check($sformatf("spo a=%0d", it.a), bus.spo, it.es);
            check($sformatf("qspo a=%0d", it.a), bus.qspo, it.eq);
            if (it.nokey) begin
                vectors++;
                if (bus.spo === 12'hCCC) begin
                    miscompares++;
                    $display("FAIL nokey a=%0d: got %h, expected not ccc",
                             it.a, bus.spo);
                end
            end
        end
    end

    // Driver: models the edge just taken, then applies the next inputs.
    task automatic step(input logic [13:0] adr, input logic w,
                        input logic [11:0] wd, input logic rst);
        item_t       it;
        logic [11:0] q;
        @(posedge clk);
        q = reset ? 12'h000 : img[bus.a];
        if (bus.we) img[bus.a] = bus.d;
        #1;
        reset  = rst;
        bus.a  = adr;
        bus.we = w;
        bus.d  = wd;
        it.a     = adr;
        it.es    = img[adr];
        it.eq    = rst ? 12'h000 : q;
        it.nokey = radius2(int'(adr)) <= 3600;
        sb.push_back(it);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16384; i++) img[i] = model(i);
        bus.a  = '0;
        bus.we = 1'b0;
        bus.d  = '0;

        if (model(8127) !== 12'hEEC || model(8185) !== 12'hDDB ||
            model(5165) !== 12'hBBA || model(8188) !== 12'hCCC)
            $display("model disagrees with hand values");

        step(14'd0, 1'b0, 12'h0, 1'b1);
        step(14'd16383, 1'b0, 12'h0, 1'b0);
        step(14'd8188, 1'b0, 12'h0, 1'b0);
        step(14'd8127, 1'b0, 12'h0, 1'b0);
        step(14'd8185, 1'b0, 12'h0, 1'b0);
        step(14'd5165, 1'b0, 12'h0, 1'b0);
        step(14'd9680, 1'b0, 12'h0, 1'b0);
        step(14'd11575, 1'b0, 12'h0, 1'b0);

        // Mid-run asynchronous reset with the centre pixel addressed.
        step(14'd8127, 1'b0, 12'h0, 1'b1);
        step(14'd8127, 1'b0, 12'h0, 1'b0);
        step(14'd8127, 1'b0, 12'h0, 1'b0);

        for (int i = 0; i < 16384; i++)
            step(14'(i), 1'b0, 12'h0, 1'b0);

        // Read-before-write at address 100, then reset keeps the data.
        step(14'd100, 1'b1, 12'h123, 1'b0);
        step(14'd100, 1'b0, 12'h0, 1'b0);
        step(14'd100, 1'b0, 12'h0, 1'b0);
        step(14'd100, 1'b0, 12'h0, 1'b1);
        step(14'd100, 1'b0, 12'h0, 1'b0);
        step(14'd100, 1'b0, 12'h0, 1'b0);

        for (int n = 0; n < 10 && sb.size() > 0; n++) @(posedge clk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/moon_sprite_rom.md
Name: moon_sprite_rom

Overview:
- 16384 x 12-bit sprite memory holding the 128x128 moon image in RGB444.
- Used by the moon sprite renderer: the renderer drives a pixel address and draws the returned colour unless it equals the transparent key 12'hCCC.
- Provides a combinational read port (spo), a registered read port (qspo), and a synchronous write overlay port.
- Initial contents are generated procedurally, so no image file is needed.

Parameters:
- RADIUS, 60: disc radius in pixels.
- RIM_W, 3: rim ring width in pixels.
- KEY_COLOR, 12'hCCC: transparent colour for outside the disc.
- BASE_COLOR, 12'hEEC: moon surface colour.
- RIM_COLOR, 12'hDDB: rim ring colour.
- CRATER_COLOR, 12'hBBA: crater colour.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high; clears qspo only.
- a  in  14  pixel address; a[6:0] = column, a[13:7] = row.
- spo  out  12  combinational read data, mem[a].
- qspo  out  12  registered read data.
- we  in  1  write enable, sampled at posedge clk.
- d  in  12  write data.

Behaviour:
- Storage: 16384 words x 12 bits, flat, address = row*128 + col.
- Initial content, computed at elaboration and identical after power-up. For each address:
  - col = a[6:0], row = a[13:7]; dx = col - 63, dy = row - 63 (signed); r2 = dx² + dy².
  - r2 > RADIUS² (3600) -> KEY_COLOR.
  - else r2 >= (RADIUS - RIM_W)² (3249) -> RIM_COLOR.
  - else point strictly inside any crater -> CRATER_COLOR. "Inside" means (col-cx)² + (row-cy)² < cr². Craters as (cx, cy, cr): (45, 40, 10), (80, 75, 14), (55, 90, 8).
  - else BASE_COLOR.
  - Evaluate rules in that priority order.
  - KEY_COLOR must never occur inside the disc.
- spo: purely combinational, spo = mem[a], zero latency. It updates immediately after a write edge for the written address.
- qspo:
  - Captures mem[a] at each posedge clk, giving one cycle of latency.
  - On an edge where we=1 and the write address equals a, qspo takes the OLD value (read-before-write).
- Write: at posedge clk, when we=1, mem[a] <= d.
  - Writes occur regardless of reset level.
  - Written data persists until overwritten; reset does not restore the image.
- Reset (asynchronous): qspo = 12'h000 immediately and while asserted. Memory and spo are unaffected.
- Address range is full 14 bits, so there is no out-of-range case. Addresses 16383 and 0 are both valid corners (KEY_COLOR initially).
- X/undefined address: no requirement. The renderer only reads valid addresses when the sprite is on.

Decomposition:
- Shared package moon_pkg:
  - SPRITE_W = 128, SPRITE_H = 128, ADDR_W = 14, RGB_W = 12.
  - KEY_COLOR, shared with the renderer's transparency test.
  - Colour constants.
- One natural sub-module: moon_pixel_gen. It is a pure function/combinational block mapping (col, row) to colour, used by the initialisation loop and reusable by a bench as a golden model.
- Memory array and ports stay in moon_sprite_rom.

Test Plan:
- Reset: assert reset mid-run with a=8127 -> qspo=12'h000 immediately; after release, next posedge -> qspo=12'hEEC.
- Corners/transparency: a=0 -> spo=12'hCCC; a=16383 -> spo=12'hCCC; a=8188 (row 63, col 124) -> spo=12'hCCC.
- Body, rim and craters:
  - a=8127 (centre) -> 12'hEEC.
  - a=8185 (row 63, col 121) -> 12'hDDB.
  - a=5165 (row 40, col 45) -> 12'hBBA.
  - a=9680 (row 75, col 80) -> 12'hBBA.
  - a=11575 (row 90, col 55) -> 12'hBBA.
- Exhaustive sweep: all 16384 addresses -> spo matches the moon_pixel_gen model; no 12'hCCC for r2 <= 3600.
- Write/read-before-write: a=100, d=12'h123, we=1 for one edge -> qspo at that edge = 12'hCCC, spo after the edge = 12'h123, qspo at the next edge (we=0) = 12'h123.
- Reset does not clear memory: after the write above, pulse reset -> qspo=0 and spo at a=100 still 12'h123.
